// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

  // Encoding 2'b11 is reserved and turned into a memory no-op.
  function automatic logic is_nop_size(input logic [1:0] size);
    return size == 2'b11;
  endfunction

endpackage

// File: rtl/data_mem_arb_pick.sv
// Round-robin selector with a burst cap; sel=0 picks port 0, sel=1 picks port 1.
module data_mem_arb_pick
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             req0,
  input  logic             req1,
  input  arb_state_e       state,
  input  logic             last,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             sel,
  output logic             valid
);

  logic under_cap;

  assign under_cap = burst_cnt < CNT_W'(MAX_BURST);

  always_comb begin
    valid = req0 | req1;
    sel   = req1;
    // Contention: the current owner keeps the port until its burst is used up.
    if (req0 && req1) begin
      case (state)
        OWN0:    sel = ~under_cap;
        OWN1:    sel = under_cap;
        default: sel = ~last;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (port 0)
// and the DMA/debug loader (port 1), returning registered responses.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        sign0,
  input  logic        sign1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_read,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic        m_sign,
  input  logic [31:0] m_dout,
  input  logic        m_exc
);

  arb_state_e       state;
  logic             last;
  logic [CNT_W-1:0] burst_cnt;
  logic             sel, pick_vld, gnt_any, same_owner;
  logic             g_we, g_sign, g_mis, g_access;
  logic [1:0]       g_size;
  logic [31:0]      g_addr, g_wdata, resp_data;
  logic             resp_err;
  logic             rvalid0_p1, rvalid1_p1, err0_p1, err1_p1;
  logic [31:0]      rdata0_p1, rdata1_p1;

  data_mem_arb_pick #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_pick (
    .req0      (req0),
    .req1      (req1),
    .state     (state),
    .last      (last),
    .burst_cnt (burst_cnt),
    .sel       (sel),
    .valid     (pick_vld)
  );

  // Stage p0: grant and combinational issue to memory
  assign gnt_any = pick_vld & ~rst;
  assign gnt0    = gnt_any & ~sel;
  assign gnt1    = gnt_any & sel;

  always_comb begin
    g_we    = sel ? we1    : we0;
    g_addr  = sel ? addr1  : addr0;
    g_wdata = sel ? wdata1 : wdata0;
    g_size  = sel ? size1  : size0;
    g_sign  = sel ? sign1  : sign0;
  end

  assign g_mis    = is_misaligned(g_size, g_addr[1:0]);
  assign g_access = gnt_any & ~g_mis & ~is_nop_size(g_size);

  assign m_read  = g_access & ~g_we;
  assign m_write = g_access & g_we;
  assign m_addr  = gnt_any ? g_addr  : '0;
  assign m_din   = gnt_any ? g_wdata : '0;
  assign m_size  = gnt_any ? g_size  : '0;
  assign m_sign  = gnt_any & g_sign;

  assign resp_data = m_read ? m_dout : '0;
  assign resp_err  = g_mis | (g_access & m_exc);

  assign same_owner = ((state == OWN0) && !sel) || ((state == OWN1) && sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else if (!pick_vld) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (same_owner) begin
      if (burst_cnt < CNT_W'(MAX_BURST))
        burst_cnt <= burst_cnt + CNT_W'(1);
    end else begin
      state     <= sel ? OWN1 : OWN0;
      last      <= sel;
      burst_cnt <= CNT_W'(1);
    end
  end

  // Stage p1: registered response to the port granted in p0
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      err0_p1    <= 1'b0;
      err1_p1    <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      rvalid0_p1 <= gnt0;
      rvalid1_p1 <= gnt1;
      err0_p1    <= gnt0 & resp_err;
      err1_p1    <= gnt1 & resp_err;
      rdata0_p1  <= gnt0 ? resp_data : '0;
      rdata1_p1  <= gnt1 ? resp_data : '0;
    end
  end

  // A reset landing in the response cycle squashes the pending response.
  assign rvalid0 = rvalid0_p1 & ~rst;
  assign rvalid1 = rvalid1_p1 & ~rst;
  assign err0    = err0_p1 & ~rst;
  assign err1    = err1_p1 & ~rst;
  assign rdata0  = rst ? '0 : rdata0_p1;
  assign rdata1  = rst ? '0 : rdata1_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed memory model and
// a response scoreboard.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, sign0, sign1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] m_addr, m_din, m_dout;
  logic        m_read, m_write, m_sign, m_exc;
  logic [1:0]  m_size;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t sb[$];

  logic [31:0] e_rd0, e_rd1;
  logic        e_er0, e_er1;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_BURST(4), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1), .sign0(sign0), .sign1(sign1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .m_addr(m_addr), .m_din(m_din), .m_read(m_read), .m_write(m_write),
    .m_size(m_size), .m_sign(m_sign), .m_dout(m_dout), .m_exc(m_exc)
  );

  // Memory model: 256 bytes, little endian, combinational read, write on clk edge.
  logic [7:0] mem [0:255];
  logic [7:0] ma;
  logic       oob;
  assign ma    = m_addr[7:0];
  assign oob   = m_addr[31:8] != 24'd0;
  assign m_exc = oob & (m_read | m_write);

  always_comb begin
    m_dout = '0;
    if (!oob) begin
      case (m_size)
        2'b00:   m_dout = {{24{m_sign & mem[ma][7]}}, mem[ma]};
        2'b01:   m_dout = {{16{m_sign & mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
        2'b10:   m_dout = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
        default: m_dout = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (m_write && !oob) begin
      mem[ma] <= m_din[7:0];
      if (m_size != 2'b00) mem[ma+8'd1] <= m_din[15:8];
      if (m_size == 2'b10) begin
        mem[ma+8'd2] <= m_din[23:16];
        mem[ma+8'd3] <= m_din[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic sg, input logic [31:0] erd, input logic eer);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; size0 = s; sign0 = sg; e_rd0 = erd; e_er0 = eer;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic sg, input logic [31:0] erd, input logic eer);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; size1 = s; sign1 = sg; e_rd1 = erd; e_er1 = eer;
  endtask

  task automatic idle_both();
    set0(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
  endtask

  // One clock: check grants mid-cycle, then the response just after the edge.
  task automatic tick(input logic eg0, input logic eg1);
    resp_t r;
    @(negedge clk);
    check("gnt0", {31'b0, gnt0}, {31'b0, eg0});
    check("gnt1", {31'b0, gnt1}, {31'b0, eg1});
    if (eg0) sb.push_back('{1'b0, e_rd0, e_er0});
    if (eg1) sb.push_back('{1'b1, e_rd1, e_er1});
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check("rvalid_own",   {31'b0, r.port ? rvalid1 : rvalid0}, 32'd1);
      check("rvalid_other", {31'b0, r.port ? rvalid0 : rvalid1}, 32'd0);
      check("rdata",        r.port ? rdata1 : rdata0, r.rdata);
      check("err",          {31'b0, r.port ? err1 : err0}, {31'b0, r.err});
    end else begin
      check("rvalid0_idle", {31'b0, rvalid0}, 32'd0);
      check("rvalid1_idle", {31'b0, rvalid1}, 32'd0);
    end
  endtask

  logic pat [9];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with requests pending: nothing may be granted or issued.
    rst = 1'b1;
    idle_both();
    set0(1'b1, 1'b1, 32'h10, 32'h1111_1111, 2'b10, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gnt0",    {31'b0, gnt0}, 32'd0);
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
    check("rst_rdata0",  rdata0, 32'h0);
    check("rst_err0",    {31'b0, err0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store word then load it back on port 0.
    set0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0);
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick(1'b1, 1'b0);
    idle_both();
    tick(1'b0, 1'b0);

    // Simultaneous single requests after reset: port 0 first, then port 1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    set1(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick(1'b1, 1'b0);
    set0(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1);
    idle_both();
    tick(1'b0, 1'b0);

    // Both held: bursts of four alternate between ports.
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    set1(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(~pat[i], pat[i]);
      check("burst_cnt_cap", {31'b0, u_dut.burst_cnt <= 3'd4}, 32'd1);
    end
    idle_both();
    tick(1'b0, 1'b0);

    // Port 1 misaligned half accesses.
    set1(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1);
    set1(1'b1, 1'b1, 32'h21, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 1'b1);
    #1;
    check("mis_m_write", {31'b0, m_write}, 32'd0);
    tick(1'b0, 1'b1);
    set1(1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1);
    set1(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0);
    tick(1'b0, 1'b1);
    idle_both();
    tick(1'b0, 1'b0);

    // Byte store and signed/unsigned byte loads.
    set0(1'b1, 1'b1, 32'h3, 32'h1234_5680, 2'b00, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0);
    set0(1'b1, 1'b0, 32'h3, 32'h0, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
    tick(1'b1, 1'b0);
    set0(1'b1, 1'b0, 32'h3, 32'h0, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
    tick(1'b1, 1'b0);
    set0(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h8000_0000, 1'b0);
    tick(1'b1, 1'b0);

    // Reserved size is a no-op; out-of-range access reports the memory exception.
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    #1;
    check("nop_m_read", {31'b0, m_read}, 32'd0);
    tick(1'b1, 1'b0);
    set0(1'b1, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0);
    idle_both();
    tick(1'b0, 1'b0);

    // Port 0 loses the tie and withdraws before being granted.
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    set1(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick(1'b0, 1'b1);
    idle_both();
    tick(1'b0, 1'b0);

    // Reset in the response cycle squashes the response.
    set0(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("pre_rst_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set1(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("sq_rvalid0", {31'b0, rvalid0}, 32'd0);
    check("sq_rdata0",  rdata0, 32'h0);
    check("sq_err0",    {31'b0, err0}, 32'd0);
    check("sq_gnt0",    {31'b0, gnt0}, 32'd0);
    check("sq_gnt1",    {31'b0, gnt1}, 32'd0);
    check("sq_m_read",  {31'b0, m_read}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1'b1, 1'b0);
    set0(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1);
    idle_both();
    tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
